// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue control with register scoreboard, branch wait/flush and halt drain.
//   clk, rst (async active-low)
//   dec_*  : decoded instruction (valid, rd/rs/rt, uses_rs/rt, reg_write, is_branch, is_halt)
//   wb_*   : retiring register write; br_* : branch resolution
//   issue, stall, flush, do_halt, busy_count, protocol_err : control/status outputs
module issue_scheduler #(
   parameter int FLUSH_CYCLES = 2,
   parameter int NREG = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   input  logic [3:0] dec_rd,
   input  logic [3:0] dec_rs,
   input  logic [3:0] dec_rt,
   input  logic       dec_uses_rs,
   input  logic       dec_uses_rt,
   input  logic       dec_reg_write,
   input  logic       dec_is_branch,
   input  logic       dec_is_halt,
   input  logic       wb_valid,
   input  logic [3:0] wb_addr,
   input  logic       br_resolve,
   input  logic       br_taken,
   output logic       issue,
   output logic       stall,
   output logic       flush,
   output logic       do_halt,
   output logic [4:0] busy_count,
   output logic       protocol_err
);
   typedef enum logic [2:0] {RUN, BR_WAIT, FLUSH, DRAIN, HALTED} state_t;
   state_t state, state_nxt;
   logic [NREG-1:0] busy, busy_nxt;
   logic [2:0] cnt;
   logic hazard;
   // hazard looks only at the registered scoreboard; a same-cycle retirement is not bypassed
   assign hazard = (dec_uses_rs & busy[dec_rs]) | (dec_uses_rt & busy[dec_rt]) | (dec_reg_write & busy[dec_rd]);
   // rst gating keeps the combinational outputs low while reset is held
   assign issue = rst & dec_valid & (state == RUN) & ~hazard;
   assign stall = rst & dec_valid & ~issue & (state != HALTED);
   assign flush = state == FLUSH;
   assign do_halt = state == HALTED;
   // clear first so a same-edge set of the same register wins
   always_comb begin
      busy_nxt = busy;
      if (wb_valid) busy_nxt[wb_addr] = 1'b0;
      if (issue && dec_reg_write && dec_rd != 4'd0) busy_nxt[dec_rd] = 1'b1;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (issue) state_nxt = dec_is_halt ? DRAIN : dec_is_branch ? BR_WAIT : RUN;
         BR_WAIT: if (br_resolve) state_nxt = br_taken ? FLUSH : RUN;
         FLUSH:   if (cnt == 3'(FLUSH_CYCLES - 1)) state_nxt = RUN;
         DRAIN:   if (busy_count == 5'd0) state_nxt = HALTED;
         default: state_nxt = state;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         busy_count <= 5'd0;
         cnt <= 3'd0;
         protocol_err <= 1'b0;
      end else begin
         busy <= busy_nxt;
         busy_count <= 5'($countones(busy_nxt));
         cnt <= (state == FLUSH) ? cnt + 3'd1 : 3'd0;
         protocol_err <= protocol_err | (wb_valid & ~busy[wb_addr]) | (br_resolve & (state != BR_WAIT));
      end
   end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and randomized checks of issue_scheduler against a behavioural model.
//   drives all DUT inputs, compares every output each cycle, prints one summary line.
module tb_issue_scheduler;
   localparam int FC = 2;
   logic clk = 1'b0, rst = 1'b0;
   logic dec_valid, dec_uses_rs, dec_uses_rt, dec_reg_write, dec_is_branch, dec_is_halt;
   logic [3:0] dec_rd, dec_rs, dec_rt, wb_addr;
   logic wb_valid, br_resolve, br_taken;
   logic issue, stall, flush, do_halt, protocol_err;
   logic [4:0] busy_count;
   int checks = 0, failures = 0, flush_seen = 0;
   bit m_busy[16];
   bit m_br, m_drain, m_halt, m_err;
   int m_flush_left;

   issue_scheduler #(.FLUSH_CYCLES(FC), .NREG(16)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_reg_write(dec_reg_write),
      .dec_is_branch(dec_is_branch), .dec_is_halt(dec_is_halt), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .br_resolve(br_resolve), .br_taken(br_taken), .issue(issue), .stall(stall), .flush(flush),
      .do_halt(do_halt), .busy_count(busy_count), .protocol_err(protocol_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pop();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic idle();
      {dec_valid, dec_uses_rs, dec_uses_rt, dec_reg_write, dec_is_branch, dec_is_halt} = '0;
      {dec_rd, dec_rs, dec_rt, wb_addr} = '0;
      {wb_valid, br_resolve, br_taken} = '0;
   endtask

   task automatic set_dec(input logic [3:0] rd, rs, rt, input logic ur, ut, rw, br, hl);
      dec_valid = 1'b1;
      dec_rd = rd; dec_rs = rs; dec_rt = rt;
      dec_uses_rs = ur; dec_uses_rt = ut; dec_reg_write = rw;
      dec_is_branch = br; dec_is_halt = hl;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      {m_br, m_drain, m_halt, m_err} = '0;
      m_flush_left = 0;
   endtask

   // called just after a falling edge with inputs already driven
   task automatic cycle();
      bit run, hz, e_issue, e_stall;
      int n;
      #1;
      run = !m_br && m_flush_left == 0 && !m_drain && !m_halt;
      hz = (dec_uses_rs && m_busy[dec_rs]) || (dec_uses_rt && m_busy[dec_rt]) || (dec_reg_write && m_busy[dec_rd]);
      e_issue = dec_valid && run && !hz;
      e_stall = dec_valid && !e_issue && !m_halt;
      n = pop();
      chk("issue", {31'd0, issue}, {31'd0, e_issue});
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("flush", {31'd0, flush}, {31'd0, m_flush_left > 0});
      chk("do_halt", {31'd0, do_halt}, {31'd0, m_halt});
      chk("busy_count", {27'd0, busy_count}, n);
      chk("protocol_err", {31'd0, protocol_err}, {31'd0, m_err});
      if (flush) flush_seen++;
      @(posedge clk);
      m_err |= (wb_valid && !m_busy[wb_addr]) || (br_resolve && !m_br);
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (e_issue && dec_reg_write && dec_rd != 0) m_busy[dec_rd] = 1'b1;
      if (m_drain && n == 0) begin m_drain = 0; m_halt = 1; end
      else if (m_flush_left > 0) m_flush_left--;
      else if (m_br && br_resolve) begin m_br = 0; m_flush_left = br_taken ? FC : 0; end
      else if (e_issue) begin
         if (dec_is_halt) m_drain = 1;
         else if (dec_is_branch) m_br = 1;
      end
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      rst = 1'b0;
      #1;
      chk({tag, "_issue"}, {31'd0, issue}, 0);
      chk({tag, "_stall"}, {31'd0, stall}, 0);
      chk({tag, "_flush"}, {31'd0, flush}, 0);
      chk({tag, "_halt"}, {31'd0, do_halt}, 0);
      chk({tag, "_cnt"}, {27'd0, busy_count}, 0);
      chk({tag, "_err"}, {31'd0, protocol_err}, 0);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
   endtask

   task automatic rand_inputs(input int halt_mod, input bit allow_err);
      int q[$];
      idle();
      if ($urandom_range(3) != 0)
         set_dec(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(7) == 0, $urandom_range(halt_mod) == 0);
      for (int i = 1; i < 16; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(2) == 0) begin
         wb_valid = 1'b1;
         wb_addr = 4'(q[$urandom_range(q.size() - 1)]);
      end else if (allow_err && $urandom_range(60) == 0) begin
         wb_valid = 1'b1;
         wb_addr = 4'($urandom);
      end
      if (m_br && $urandom_range(2) == 0) begin
         br_resolve = 1'b1;
         br_taken = 1'($urandom);
      end else if (allow_err && $urandom_range(80) == 0) br_resolve = 1'b1;
   endtask

   initial begin
      idle();
      model_clear();
      @(negedge clk);
      reset_check("rst0");
      // scoreboard hazard on r3, retired later
      set_dec(4'd3, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      set_dec(4'd8, 4'd3, 4'd0, 1, 0, 1, 0, 0);
      for (int i = 1; i < 4; i++) cycle();
      wb_valid = 1'b1; wb_addr = 4'd3; cycle();
      wb_valid = 1'b0; cycle();
      chk("raw_cnt_after", {27'd0, busy_count}, 1);
      idle(); wb_valid = 1'b1; wb_addr = 4'd8; cycle();
      // taken branch: stall in wait, flush exactly FC cycles
      flush_seen = 0;
      set_dec(4'd0, 4'd1, 4'd0, 1, 0, 0, 1, 0); wb_valid = 1'b0; cycle();
      set_dec(4'd4, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle(); cycle();
      br_resolve = 1'b1; br_taken = 1'b1; cycle();
      br_resolve = 1'b0; br_taken = 1'b0;
      for (int i = 0; i < FC + 1; i++) cycle();
      chk("flush_len", flush_seen, FC);
      // not-taken branch
      flush_seen = 0;
      set_dec(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0); wb_valid = 1'b1; wb_addr = 4'd4; cycle();
      wb_valid = 1'b0; set_dec(4'd6, 4'd0, 4'd0, 0, 0, 0, 0, 0);
      br_resolve = 1'b1; br_taken = 1'b0; cycle();
      br_resolve = 1'b0; cycle(); cycle();
      chk("nt_flush", flush_seen, 0);
      // drain with r5, r7 pending; branch+halt counts as halt
      set_dec(4'd5, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      set_dec(4'd7, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      set_dec(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 1); cycle();
      idle(); cycle();
      wb_valid = 1'b1; wb_addr = 4'd5; cycle();
      wb_addr = 4'd7; cycle();
      wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("halt_hold", {31'd0, do_halt}, 1);
      reset_check("rst1");
      // r0 write never marks busy; stray writeback flags an error
      set_dec(4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      idle(); cycle();
      wb_valid = 1'b1; wb_addr = 4'd9; cycle();
      wb_valid = 1'b0; cycle(); cycle();
      chk("err_sticky", {31'd0, protocol_err}, 1);
      reset_check("rst2");
      // reset in the middle of a flush with two registers busy
      set_dec(4'd1, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      set_dec(4'd2, 4'd0, 4'd0, 0, 0, 1, 0, 0); cycle();
      set_dec(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0); cycle();
      idle(); br_resolve = 1'b1; br_taken = 1'b1; cycle();
      idle(); #1;
      chk("pre_rst_flush", {31'd0, flush}, 1);
      chk("pre_rst_cnt", {27'd0, busy_count}, 2);
      #2;
      set_dec(4'd1, 4'd2, 4'd0, 1, 0, 1, 0, 0);
      reset_check("rst_flush");
      cycle();
      // randomized episodes, each starting from reset
      for (int e = 0; e < 10; e++) begin
         for (int c = 0; c < 250; c++) begin
            rand_inputs(e < 5 ? 200 : 40, e >= 7);
            cycle();
         end
         idle();
         reset_check("rst_ep");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
